cgc_wake_seq: RTL and testbench
===============================

# cgc_wake_seq

Clock-gate enable sequencer that owns the `en`/`te` inputs of one ctech clock-gate cell and shares the gated clock among `N_REQ` requesters. Requesters ask for the clock with a req/ack handshake. The sequencer opens the gate, waits a programmable settle time, grants, and holds the clock through a programmable hysteresis window after the last request drops. It sits in the ungated (free-running) clock domain beside the gate cell, for example in front of a DFx secure-plugin datapath.

## Interface
- `N_REQ`, 4: number of requesters, 1..16.
- `WAKE_DLY`, 2: cycles between gate enable and first ack, ≥1.
- `HYST_W`, 8: width of the hysteresis count input.

- `clk` input 1: free-running clock (the same clock that feeds the gate cell).
- `rst_b` input 1: asynchronous, active-low reset.
- `req` input `N_REQ`: per-requester clock request, level.
- `ack` output `N_REQ`: per-requester grant, registered.
- `te` input 1: test mode; forces the clock on.
- `hyst_cfg` input `HYST_W`: hysteresis length; quasi-static, sampled on entry to HYST.
- `cg_en` output 1: to gate cell `en`, registered.
- `cg_te` output 1: to gate cell `te`, equal to `te` (combinational).
- `clk_on` output 1: state ≠ OFF.
- `off_cycles` output 16: OFF-cycle count. Present only with the macro.

## Operation
- States: OFF, WAKE, ON, HYST. Reset state is OFF.
- Reset values: `cg_en`=0, `ack`=0, `clk_on`=0, `off_cycles`=0, wake counter 0, hysteresis counter 0. `cg_te` follows `te` even during reset.
- OFF:
  - Any `req` bit with `te`=0 goes to WAKE, sets `cg_en`=1, and loads the wake counter with `WAKE_DLY`-1.
  - Any `req` bit with `te`=1 goes straight to ON.
- WAKE:
  - Wake counter 0 and some `req` high goes to ON.
  - Wake counter 0 and all `req` low goes to HYST.
  - Otherwise the wake counter decrements.
  - `te`=1 ends WAKE immediately (same transitions as counter 0).
- ON:
  - `ack[i]` is registered from `req[i]` (1-cycle follow).
  - All `req` low goes to HYST and loads the hysteresis counter from `hyst_cfg`.
- HYST:
  - Any `req` high goes to ON; ack follows next edge. This takes priority over expiry.
  - Counter 0 goes to OFF with `cg_en`=0.
  - Otherwise the counter decrements.
- `ack` is 0 in every state except ON, and in the edge that enters ON it is loaded from `req`.
- Handshake rules:
  - A requester holds `req` until `ack` is seen, and must not use the gated clock before `ack`.
  - Deasserting `req` before `ack` is legal; the request is withdrawn.
- `cg_en` stays 1 through WAKE, ON and HYST. It changes only on OFF entry and exit.
- Async reset mid-operation: all outputs drop to their reset values immediately. The state is OFF after reset release regardless of `req`. A held `req` restarts the WAKE sequence on the first edge after release.

## Timing
- `req` first sampled at edge E0 in OFF (`te`=0): `cg_en`=1 after E0, `ack`=1 after edge E0+`WAKE_DLY`.
- Same case with `te`=1: `ack`=1 after E0, and WAKE is skipped.
- In ON: `req[i]` rise or fall is reflected on `ack[i]` after 1 edge.
- All `req` sampled low at edge E (ON): `ack`=0 after E, `cg_en`=0 after edge E+`hyst_cfg`+1. With `hyst_cfg`=0, HYST lasts exactly one cycle.
- `req` sampled high at the edge where the HYST counter is 0: the sequencer goes to ON, not OFF, and `cg_en` never drops.

## Configuration
- Macro `CGC_WAKE_SEQ_OFF_CNT_EN`.
- Defined: `off_cycles` port exists. It increments on every edge where state is OFF, saturates at 0xFFFF, and is cleared only by `rst_b`.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset/idle: `rst_b`=0, then release with `req`=0 → `cg_en`=0, `ack`=0, `clk_on`=0 held for 20 cycles.
- Wake: `WAKE_DLY`=2, `req`=4'b0001 sampled at E0 → `cg_en`=1 after E0, `ack`=4'b0001 after E0+2. Then raising `req[2]` → `ack`=4'b0101 one edge later.
- Hysteresis: `hyst_cfg`=5, all `req` drop at E → `ack`=0 after E, `cg_en`=0 after E+6. Repeat with `hyst_cfg`=0 → `cg_en`=0 after E+1.
- Rewake race: `hyst_cfg`=3, `req[1]` reasserted at the counter-0 edge → state ON, `ack[1]`=1 next edge, `cg_en` never deasserts.
- Test mode: `te`=1 with `req`=4'b1000 in OFF → `cg_te`=1 immediately, `ack[3]`=1 after one edge, WAKE skipped.
- Mid-op reset plus counter: reset asserted in ON → `ack`/`cg_en` drop asynchronously. With the macro defined, after release 0x10005 OFF cycles → `off_cycles`=0xFFFF (saturated).

Source files
------------

// File: rtl/cgc_wake_seq.sv
// -----------------------------------------------------------------------------
// cgc_wake_seq
//
// Clock-gate enable sequencer. Drives the en/te pins of one clock-gate cell
// and shares the gated clock among N_REQ requesters through a level req/ack
// handshake. On the first request the gate is opened. After WAKE_DLY cycles
// of settle time the ack is granted. The gate stays open through a
// programmable hysteresis window after the last request drops. The block
// runs in the free-running clock domain next to the gate cell.
//
// Optional feature (compile-time macro CGC_WAKE_SEQ_OFF_CNT_EN):
//   adds the off_cycles port, a saturating 16-bit count of cycles spent OFF.
//
// Parameters:
//   N_REQ    - number of requesters (1..16)
//   WAKE_DLY - cycles from gate enable to first ack (>= 1)
//   HYST_W   - width of the hysteresis length input
//
// Ports:
//   clk        in   free-running clock, same clock that feeds the gate cell
//   rst_b      in   asynchronous active-low reset
//   req        in   per-requester clock request (level)
//   ack        out  per-requester grant (registered)
//   te         in   test mode, forces the clock on
//   hyst_cfg   in   hysteresis length, sampled when HYST is entered
//   cg_en      out  gate cell enable (registered)
//   cg_te      out  gate cell test enable, a combinational copy of te
//   clk_on     out  high whenever the sequencer is not OFF
//   off_cycles out  saturating OFF-cycle count (only with the macro)
// -----------------------------------------------------------------------------
module cgc_wake_seq #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WAKE_DLY = 2,
    parameter int unsigned HYST_W   = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  ack,
    input  logic              te,
    input  logic [HYST_W-1:0] hyst_cfg,
    output logic              cg_en,
    output logic              cg_te,
    output logic              clk_on
`ifdef CGC_WAKE_SEQ_OFF_CNT_EN
    ,
    output logic [15:0]       off_cycles
`endif
);

    // The wake counter needs at least one bit even when WAKE_DLY is 1.
    localparam int unsigned WCW = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
    localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_DLY - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_ON,
        ST_HYST
    } state_e;

    state_e             state_q;
    logic [N_REQ-1:0]   ack_q;
    logic               cg_en_q;
    logic [WCW-1:0]     wake_cnt_q;
    logic [HYST_W-1:0]  hyst_cnt_q;

    logic any_req;
    assign any_req = |req;

    // NOTE: sequential state is written only with non-blocking assignments so
    // that every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_OFF;
            ack_q      <= '0;
            cg_en_q    <= 1'b0;
            wake_cnt_q <= '0;
            hyst_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    ack_q <= '0;
                    if (any_req) begin
                        cg_en_q <= 1'b1;
                        if (te) begin
                            // Test mode already forces the clock: skip settle.
                            state_q <= ST_ON;
                            ack_q   <= req;
                        end else begin
                            state_q    <= ST_WAKE;
                            wake_cnt_q <= WAKE_LOAD;
                        end
                    end
                end

                ST_WAKE: begin
                    ack_q <= '0;
                    if (wake_cnt_q == '0 || te) begin
                        if (any_req) begin
                            state_q <= ST_ON;
                            ack_q   <= req;
                        end else begin
                            // Every request was withdrawn while settling.
                            state_q    <= ST_HYST;
                            hyst_cnt_q <= hyst_cfg;
                        end
                    end else begin
                        wake_cnt_q <= wake_cnt_q - WCW'(1);
                    end
                end

                ST_ON: begin
                    ack_q <= req;
                    if (!any_req) begin
                        state_q    <= ST_HYST;
                        hyst_cnt_q <= hyst_cfg;
                    end
                end

                ST_HYST: begin
                    ack_q <= '0;
                    // A new request wins over expiry so the gate never blips.
                    if (any_req) begin
                        state_q <= ST_ON;
                        ack_q   <= req;
                    end else if (hyst_cnt_q == '0) begin
                        state_q <= ST_OFF;
                        cg_en_q <= 1'b0;
                    end else begin
                        hyst_cnt_q <= hyst_cnt_q - HYST_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_OFF;
                    ack_q   <= '0;
                    cg_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack    = ack_q;
    assign cg_en  = cg_en_q;
    assign cg_te  = te;
    assign clk_on = (state_q != ST_OFF);

`ifdef CGC_WAKE_SEQ_OFF_CNT_EN
    logic [15:0] off_cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            off_cnt_q <= '0;
        end else if (state_q == ST_OFF && off_cnt_q != 16'hFFFF) begin
            off_cnt_q <= off_cnt_q + 16'd1;
        end
    end

    assign off_cycles = off_cnt_q;
`endif

endmodule

// File: tb/tb_cgc_wake_seq.sv
// -----------------------------------------------------------------------------
// tb_cgc_wake_seq
//
// Directed testbench for cgc_wake_seq with the default parameters
// (N_REQ=4, WAKE_DLY=2, HYST_W=8). Inputs are driven 1 ns after the rising
// edge. Outputs are checked 1 ns after the edge that is under test.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cgc_wake_seq;

    logic       clk;
    logic       rst_b;
    logic [3:0] req;
    logic [3:0] ack;
    logic       te;
    logic [7:0] hyst_cfg;
    logic       cg_en;
    logic       cg_te;
    logic       clk_on;
`ifdef CGC_WAKE_SEQ_OFF_CNT_EN
    logic [15:0] off_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cgc_wake_seq #(
        .N_REQ    (4),
        .WAKE_DLY (2),
        .HYST_W   (8)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req        (req),
        .ack        (ack),
        .te         (te),
        .hyst_cfg   (hyst_cfg),
        .cg_en      (cg_en),
        .cg_te      (cg_te),
        .clk_on     (clk_on)
`ifdef CGC_WAKE_SEQ_OFF_CNT_EN
        ,
        .off_cycles (off_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the directed sequence is finite, this only guards the run.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b    = 1'b0;
        req      = 4'b0000;
        te       = 1'b0;
        hyst_cfg = 8'd0;

        // ---------------- reset / idle ----------------
        #3;
        check("rst_cg_en", 32'(cg_en), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_clk_on", 32'(clk_on), 32'd0);
        check("rst_cg_te0", 32'(cg_te), 32'd0);
        te = 1'b1;
        #1;
        check("rst_cg_te1", 32'(cg_te), 32'd1);
        te = 1'b0;
        step();
        step();
        rst_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_outputs", 32'({cg_en, ack, clk_on}), 32'd0);
        end

        // ---------------- wake ----------------
        req = 4'b0001;
        step();  // E0
        check("wake_e0_cg_en", 32'(cg_en), 32'd1);
        check("wake_e0_ack", 32'(ack), 32'd0);
        check("wake_e0_clk_on", 32'(clk_on), 32'd1);
        step();  // E0+1
        check("wake_e1_ack", 32'(ack), 32'd0);
        step();  // E0+2
        check("wake_e2_ack", 32'(ack), 32'b0001);
        req = 4'b0101;
        step();
        check("on_follow_rise", 32'(ack), 32'b0101);

        // ---------------- hysteresis, hyst_cfg = 5 ----------------
        hyst_cfg = 8'd5;
        req = 4'b0000;
        step();  // E
        check("hyst5_ack_drop", 32'(ack), 32'd0);
        check("hyst5_e_cg_en", 32'(cg_en), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("hyst5_hold_cg_en", 32'(cg_en), 32'd1);
        end
        step();  // E+6
        check("hyst5_off_cg_en", 32'(cg_en), 32'd0);
        check("hyst5_off_clk_on", 32'(clk_on), 32'd0);

        // ---------------- hysteresis, hyst_cfg = 0 ----------------
        req = 4'b0001;
        step();
        step();
        step();
        check("hyst0_wake_ack", 32'(ack), 32'b0001);
        hyst_cfg = 8'd0;
        req = 4'b0000;
        step();  // E
        check("hyst0_e_cg_en", 32'(cg_en), 32'd1);
        check("hyst0_e_ack", 32'(ack), 32'd0);
        step();  // E+1
        check("hyst0_off_cg_en", 32'(cg_en), 32'd0);

        // ---------------- rewake race, hyst_cfg = 3 ----------------
        req = 4'b0010;
        step();
        step();
        step();
        check("race_wake_ack", 32'(ack), 32'b0010);
        hyst_cfg = 8'd3;
        req = 4'b0000;
        step();  // E: counter loaded with 3
        for (int i = 1; i <= 3; i++) begin
            step();  // counter 2, 1, 0
            check("race_hold_cg_en", 32'(cg_en), 32'd1);
        end
        req = 4'b0010;
        step();  // counter-0 edge with request high
        check("race_ack", 32'(ack), 32'b0010);
        check("race_cg_en", 32'(cg_en), 32'd1);
        check("race_clk_on", 32'(clk_on), 32'd1);
        hyst_cfg = 8'd0;
        req = 4'b0000;
        step();
        step();
        check("race_back_off", 32'(cg_en), 32'd0);

        // ---------------- request withdrawn during WAKE ----------------
        req = 4'b0001;
        step();  // WAKE, counter 1
        req = 4'b0000;
        step();  // counter 0
        check("wd_wake_ack", 32'(ack), 32'd0);
        step();  // WAKE -> HYST
        check("wd_hyst_cg_en", 32'(cg_en), 32'd1);
        check("wd_hyst_ack", 32'(ack), 32'd0);
        step();  // HYST -> OFF
        check("wd_off_cg_en", 32'(cg_en), 32'd0);

        // ---------------- test mode ----------------
        te = 1'b1;
        req = 4'b1000;
        #1;
        check("te_cg_te", 32'(cg_te), 32'd1);
        check("te_pre_ack", 32'(ack), 32'd0);
        step();
        check("te_ack", 32'(ack), 32'b1000);
        check("te_cg_en", 32'(cg_en), 32'd1);
        te = 1'b0;
        step();
        check("te_hold_ack", 32'(ack), 32'b1000);

        // ---------------- mid-op asynchronous reset ----------------
        rst_b = 1'b0;
        #1;
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_cg_en", 32'(cg_en), 32'd0);
        check("mid_rst_clk_on", 32'(clk_on), 32'd0);
        step();
        check("mid_rst_hold_ack", 32'(ack), 32'd0);
        rst_b = 1'b1;
        step();  // first edge after release restarts WAKE
        check("rewake_cg_en", 32'(cg_en), 32'd1);
        check("rewake_ack0", 32'(ack), 32'd0);
        step();
        check("rewake_ack1", 32'(ack), 32'd0);
        step();
        check("rewake_ack2", 32'(ack), 32'b1000);
        req = 4'b0000;
        step();
        step();
        check("rewake_off", 32'(cg_en), 32'd0);

`ifdef CGC_WAKE_SEQ_OFF_CNT_EN
        // ---------------- OFF-cycle counter saturation ----------------
        rst_b = 1'b0;
        #1;
        check("offcnt_rst", 32'(off_cycles), 32'd0);
        rst_b = 1'b1;
        step();
        step();
        step();
        check("offcnt_3", 32'(off_cycles), 32'd3);
        repeat (32'h10002) @(posedge clk);
        #1;
        check("offcnt_sat", 32'(off_cycles), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
